// File: rtl/uart_tx_if.sv
// Write-side handshake for uart_tx: one word moves on write_valid && write_ready.
interface uart_tx_if #(
  parameter int BUFFER_WIDTH = 8
);
  logic [BUFFER_WIDTH-1:0] write_data;
  logic                    write_valid;
  logic                    write_ready;

  modport master (output write_data, output write_valid, input write_ready);
  modport slave  (input write_data, input write_valid, output write_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: serialises one word per handshake, LSB-first, with
// optional parity and one or two stop bits. All outputs come from flops.
module uart_tx #(
  parameter int BUFFER_WIDTH = 8,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLK_FREQ     = 12_000_000,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  uart_tx_if.slave wr,
  output logic    tx,
  output logic    busy
);
  localparam int CLK_CYCLES_PER_BIT     = CLK_FREQ / BAUD_RATE;
  localparam int CLK_CYCLE_COUNTER_BITS = $clog2(CLK_CYCLES_PER_BIT);
  localparam int BIT_COUNTER_BITS       = $clog2(BUFFER_WIDTH) + 1;

  localparam logic [CLK_CYCLE_COUNTER_BITS-1:0] CNT_RELOAD =
    CLK_CYCLE_COUNTER_BITS'(CLK_CYCLES_PER_BIT - 1);
  localparam logic [BIT_COUNTER_BITS-1:0] BIT_RELOAD = BIT_COUNTER_BITS'(BUFFER_WIDTH);
  localparam logic [BIT_COUNTER_BITS-1:0] BIT_LAST   = BIT_COUNTER_BITS'(1);

  if (CLK_CYCLES_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (PARITY > 2 || PARITY < 0) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [6:0] {
    S_RESET  = 7'b0000001,
    S_IDLE   = 7'b0000010,
    S_START  = 7'b0000100,
    S_DATA   = 7'b0001000,
    S_PARITY = 7'b0010000,
    S_STOP   = 7'b0100000,
    S_ERROR  = 7'b1000000
  } state_t;

  state_t                              r_state;
  logic                                r_tx;
  logic                                r_ready;
  logic                                r_busy;
  logic                                r_parity;
  logic                                r_stop_cnt;
  logic [BUFFER_WIDTH-1:0]             r_shift;
  logic [BIT_COUNTER_BITS-1:0]         r_bit_cnt;
  logic [CLK_CYCLE_COUNTER_BITS-1:0]   r_clk_cnt;
  logic                                w_bit_end;

  assign w_bit_end      = (r_clk_cnt == '0);
  assign tx             = r_tx;
  assign busy           = r_busy;
  assign wr.write_ready = r_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_RESET;
      r_tx       <= 1'b1;
      r_ready    <= 1'b0;
      r_busy     <= 1'b1;
      r_parity   <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= BIT_RELOAD;
      r_clk_cnt  <= CNT_RELOAD;
    end else begin
      // Every state change happens on a bit end, so the free-running reload
      // doubles as the load-on-entry of the clock counter.
      r_clk_cnt <= w_bit_end ? CNT_RELOAD : r_clk_cnt - CLK_CYCLE_COUNTER_BITS'(1);
      case (r_state)
        S_RESET: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        S_IDLE: begin
          r_clk_cnt <= CNT_RELOAD;
          if (wr.write_valid && r_ready) begin
            r_shift    <= wr.write_data;
            r_parity   <= (PARITY == 1) ? ~^wr.write_data : ^wr.write_data;
            r_bit_cnt  <= BIT_RELOAD;
            r_stop_cnt <= 1'b0;
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt - BIT_LAST;
            if (r_bit_cnt == BIT_LAST) begin
              if (PARITY != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_tx <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (STOP_BITS == 2 && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_ERROR: begin
          r_tx    <= 1'b1;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
        end
        default: begin
          r_state <= S_ERROR;
          r_tx    <= 1'b1;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances cover no-parity/1-stop,
// even-parity/2-stop and odd-parity/1-stop framing at 104 clocks per bit.
module tb_uart_tx;
  localparam int CPB = 104;

  logic clk;
  logic rst_n;
  logic [7:0] dat [3];
  logic       v   [3];
  logic       txs [3];
  logic       bsy [3];
  int         cyc;
  int         n_chk;
  int         n_fail;
  int         last_h;
  logic       samp [1250];

  uart_tx_if #(.BUFFER_WIDTH(8)) w0 ();
  uart_tx_if #(.BUFFER_WIDTH(8)) w1 ();
  uart_tx_if #(.BUFFER_WIDTH(8)) w2 ();

  assign w0.write_data = dat[0];
  assign w0.write_valid = v[0];
  assign w1.write_data = dat[1];
  assign w1.write_valid = v[1];
  assign w2.write_data = dat[2];
  assign w2.write_valid = v[2];

  uart_tx #(.PARITY(0), .STOP_BITS(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .wr(w0.slave), .tx(txs[0]), .busy(bsy[0]));
  uart_tx #(.PARITY(2), .STOP_BITS(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .wr(w1.slave), .tx(txs[1]), .busy(bsy[1]));
  uart_tx #(.PARITY(1), .STOP_BITS(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .wr(w2.slave), .tx(txs[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic rdy(input int k);
    case (k)
      0:       return w0.write_ready;
      1:       return w1.write_ready;
      default: return w2.write_ready;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge. Sends one word, records every cycle of the frame
  // plus the following cycle, and checks each bit at its first, middle and
  // last clock. Returns at the negedge of the first IDLE cycle after the frame.
  task automatic do_frame(input string nm, input int k, input logic [7:0] data,
                          input logic [11:0] exp, input int nbits, input bit hold,
                          input logic [7:0] after_data);
    int  n;
    int  f;
    logic st_bad;
    logic e;
    dat[k] = data;
    v[k]   = 1'b1;
    n = 0;
    while (!rdy(k) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready_wait"}, 32'(rdy(k)), 32'd1);
    if (!rdy(k)) begin
      v[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_h = cyc;
    dat[k] = after_data;
    if (!hold) v[k] = 1'b0;
    f = nbits * CPB;
    st_bad = 1'b0;
    for (int c = 0; c <= f; c++) begin
      @(negedge clk);
      samp[c] = txs[k];
      if (c < f && (rdy(k) || !bsy[k])) st_bad = 1'b1;
    end
    chk({nm, "_busy_not_ready"}, 32'(st_bad), 32'd0);
    chk({nm, "_idle_after"}, {29'd0, rdy(k), bsy[k], samp[f]}, {29'd0, 1'b1, 1'b0, 1'b1});
    for (int i = 0; i < nbits; i++) begin
      e = exp[i];
      chk($sformatf("%s_bit%0d", nm, i),
          {29'd0, samp[i*CPB], samp[i*CPB + CPB/2], samp[i*CPB + CPB - 1]},
          {29'd0, e, e, e});
    end
  endtask

  typedef struct {
    int          k;
    logic [7:0]  data;
    logic [11:0] exp;
    int          nbits;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int h1;
    n_chk  = 0;
    n_fail = 0;
    last_h = 0;

    // Line bit i of each frame is exp[i]: start, data LSB-first, parity, stops.
    tbl[0] = '{0, 8'hA5, 12'b0000_1101001010, 10};
    tbl[1] = '{0, 8'h01, 12'b0000_1000000010, 10};
    tbl[2] = '{0, 8'h80, 12'b0000_1100000000, 10};
    tbl[3] = '{1, 8'h07, 12'b111000001110, 12};
    tbl[4] = '{1, 8'h00, 12'b110000000000, 12};
    tbl[5] = '{2, 8'h07, 12'b010000001110, 11};
    tbl[6] = '{2, 8'h00, 12'b011000000000, 11};

    for (int k = 0; k < 3; k++) begin
      dat[k] = 8'h00;
      v[k]   = 1'b0;
    end
    rst_n  = 1'b0;
    v[0]   = 1'b1;
    dat[0] = 8'hA5;

    repeat (5) begin
      @(negedge clk);
      chk("rst_tx", 32'(txs[0]), 32'd1);
      chk("rst_ready", 32'(rdy(0)), 32'd0);
      chk("rst_busy", 32'(bsy[0]), 32'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(rdy(0)), 32'd1);
    chk("post_rst_tx", 32'(txs[0]), 32'd1);
    chk("post_rst_busy", 32'(bsy[0]), 32'd0);
    v[0] = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      do_frame($sformatf("vec%0d", i), tbl[i].k, tbl[i].data, tbl[i].exp, tbl[i].nbits, 1'b0, tbl[i].data);

    // Word changes after the handshake must not reach the line.
    do_frame("stable", 0, 8'hC3, 12'b0000_1110000110, 10, 1'b0, 8'h3C);

    // valid held high: exactly one IDLE cycle between frames.
    do_frame("b2b0", 0, 8'h00, 12'b0000_1000000000, 10, 1'b1, 8'hFF);
    h1 = last_h;
    do_frame("b2b1", 0, 8'hFF, 12'b0000_1111111110, 10, 1'b0, 8'hFF);
    chk("b2b_gap", 32'(last_h - h1), 32'd1041);

    // Reset in the middle of the DATA state.
    dat[0] = 8'h00;
    v[0]   = 1'b1;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    repeat (300) @(negedge clk);
    chk("mid_in_data", 32'(txs[0]), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", 32'(txs[0]), 32'd1);
    chk("mid_rst_ready", 32'(rdy(0)), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", 32'(rdy(0)), 32'd1);
    do_frame("after_rst", 0, 8'h55, 12'b0000_1010101010, 10, 1'b0, 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
